// File: rtl/q_measurement_mc.sv
// q_measurement_mc: multi-channel pulse-count charge measurement; define Q_MEAS_TIMEOUT_EN to enable the arm timeout
module q_measurement_mc #(
    parameter int N_CH        = 4,
    parameter int BUS_WIDTH   = 10,
    parameter int CNT_WIDTH   = 8,
    parameter int WTD_WIDTH   = 2,
    parameter int Q_PER_PULSE = 30,
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      ack,
    input  logic [N_CH-1:0]           q_serialized,
    output logic                      busy,
    output logic                      ready,
    output logic [N_CH*BUS_WIDTH-1:0] q_measured,
    output logic [N_CH-1:0]           overflow,
    output logic                      timeout
);
    localparam int PW = CNT_WIDTH + $clog2(Q_PER_PULSE + 1);
    localparam logic [WTD_WIDTH-1:0] WTD_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] Q_MAX = PW'((64'd1 << BUS_WIDTH) - 64'd1);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;

    state_t                         state;
    logic [1:0]                     rst_sync;
    logic                           rst_sn;
    logic [N_CH-1:0]                sync1, sync2, sync3, edges, ovf;
    logic [N_CH-1:0][CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [N_CH*BUS_WIDTH-1:0]      res;
    logic [WTD_WIDTH-1:0]           wtd;
    logic                           start_d, any_edge, to_hit;

    // reset asserts immediately, releases only on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_sn = rst_sync[1];

    // two-flop synchroniser plus edge register per channel
    always_ff @(posedge clk or negedge rst_sn) begin
        if (!rst_sn) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= q_serialized;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end
    assign edges    = sync2 & ~sync3;
    assign any_edge = |edges;

    // per-channel saturating increment and full-width clipped result
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [PW-1:0] prod;
        assign prod       = PW'(cnt[g]) * PW'(Q_PER_PULSE);
        assign cnt_nxt[g] = cnt[g] + CNT_WIDTH'(edges[g] && cnt[g] != CNT_MAX);
        assign ovf[g]     = cnt[g] == CNT_MAX || prod > Q_MAX;
        assign res[g*BUS_WIDTH +: BUS_WIDTH] = prod > Q_MAX ? '1 : prod[BUS_WIDTH-1:0];
    end

`ifdef Q_MEAS_TIMEOUT_EN
    localparam int AW = $clog2(ARM_TIMEOUT + 1);
    logic [AW-1:0] arm_cnt;
    assign to_hit = state == ARMED && start && !any_edge && arm_cnt == AW'(ARM_TIMEOUT - 1);
    // count idle cycles while armed; timeout flag lives for the DONE it caused
    always_ff @(posedge clk or negedge rst_sn) begin
        if (!rst_sn) begin
            arm_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            arm_cnt <= (state == ARMED && start) ? arm_cnt + 1'b1 : '0;
            timeout <= to_hit || (timeout && state == DONE && start && !ack);
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // measurement FSM with registered status outputs and result latch
    always_ff @(posedge clk or negedge rst_sn) begin
        if (!rst_sn) begin
            state      <= IDLE;
            start_d    <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            q_measured <= '0;
            overflow   <= '0;
            cnt        <= '0;
            wtd        <= WTD_MAX;
        end else begin
            start_d <= start;
            if (!start) begin
                state <= IDLE;
                busy  <= 1'b0;
                ready <= 1'b0;
                cnt   <= '0;
                wtd   <= WTD_MAX;
            end else begin
                case (state)
                    IDLE: begin
                        if (!start_d) begin
                            state    <= ARMED;
                            busy     <= 1'b1;
                            overflow <= '0;
                            cnt      <= '0;
                        end
                    end
                    ARMED: begin
                        if (any_edge) begin
                            state <= MEASURE;
                            cnt   <= cnt_nxt;
                            wtd   <= WTD_MAX;
                        end else if (to_hit) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            ready      <= 1'b1;
                            q_measured <= '0;
                            overflow   <= '0;
                        end
                    end
                    MEASURE: begin
                        if (any_edge) begin
                            cnt <= cnt_nxt;
                            wtd <= WTD_MAX;
                        end else if (wtd == '0) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            ready      <= 1'b1;
                            q_measured <= res;
                            overflow   <= ovf;
                            wtd        <= WTD_MAX;
                        end else begin
                            wtd <= wtd - 1'b1;
                        end
                    end
                    DONE: begin
                        if (ack) begin
                            state <= IDLE;
                            ready <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_q_measurement_mc.sv
// tb_q_measurement_mc: directed bench with a pulse-count result model for q_measurement_mc
module tb_q_measurement_mc;
    localparam int QP   = 30;
    localparam int CMAX = 63;
    localparam int QMAX = 1023;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, ack = 1'b0;
    logic [1:0]  q_ser = 2'b00;
    logic        busy, ready, timeout;
    logic [19:0] q_measured;
    logic [1:0]  overflow;

    int          tests = 0, fails = 0;
    logic [19:0] exp_q = '0, held_q = '0;
    logic [1:0]  exp_ovf = '0;
    logic        exp_to = 1'b0, done_ok = 1'b0;

    q_measurement_mc #(
        .N_CH(2), .BUS_WIDTH(10), .CNT_WIDTH(6), .WTD_WIDTH(2), .Q_PER_PULSE(QP), .ARM_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .q_serialized(q_ser),
        .busy(busy), .ready(ready), .q_measured(q_measured), .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected result for n pulses: counter saturates, product clips
    function automatic logic [9:0] q_of(input int n);
        int p;
        p = (n > CMAX ? CMAX : n) * QP;
        return p > QMAX ? 10'(QMAX) : 10'(p);
    endfunction

    function automatic logic ovf_of(input int n);
        return n >= CMAX || n * QP > QMAX;
    endfunction

    task automatic set_exp(input int n0, input int n1);
        exp_q   = {q_of(n1), q_of(n0)};
        exp_ovf = {ovf_of(n1), ovf_of(n0)};
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] mask, input int n, input int low);
        repeat (n) begin
            q_ser = mask;
            tick(1);
            q_ser = 2'b00;
            tick(low);
        end
    endtask

    task automatic arm();
        start = 1'b0;
        tick(2);
        start = 1'b1;
        tick(1);
        chk("armed_busy", 32'(busy), 1);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 60) begin
            tick(1);
            k++;
        end
        chk("ready_reached", 32'(ready), 1);
    endtask

    task automatic do_ack();
        chk("ready_before_ack", 32'(ready), 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("ready_drop_after_ack", 32'(ready), 0);
        held_q  = exp_q;
        done_ok = 1'b0;
    endtask

    // every cycle: results must equal the model's current or held values
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_allowed", 32'(ready & ~done_ok), 0);
            chk("busy_ready_excl", 32'(busy & ready), 0);
            chk("q_measured", 32'(q_measured), 32'(ready ? exp_q : held_q));
            if (ready) chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("timeout", 32'(timeout), 32'(ready & exp_to));
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish");
        $fatal(1, "sim timeout");
    end

    initial begin
        int n;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_q", 32'(q_measured), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("model_q5", 32'(q_of(5)), 150);
        chk("model_q40", 32'(q_of(40)), 1023);
        chk("model_q2", 32'(q_of(2)), 60);
        chk("model_ovf3", 32'(ovf_of(3)), 0);
        chk("model_ovf70", 32'(ovf_of(70)), 1);
        #21 rst_n = 1'b1;
        tick(3);

        arm();
        set_exp(5, 3);
        pulse(2'b11, 3, 1);
        pulse(2'b01, 2, 1);
        done_ok = 1'b1;
        wait_ready();
        chk("ch0_150", 32'(q_measured[9:0]), 150);
        chk("ch1_90", 32'(q_measured[19:10]), 90);
        chk("ovf_00", 32'(overflow), 0);
        tick(2);
        chk("ready_holds", 32'(ready), 1);
        do_ack();
        tick(5);
        chk("no_rearm_busy", 32'(busy), 0);
        chk("no_rearm_ready", 32'(ready), 0);

        arm();
        set_exp(40, 0);
        pulse(2'b01, 40, 1);
        done_ok = 1'b1;
        wait_ready();
        chk("clip40_ch0", 32'(q_measured[9:0]), 1023);
        chk("clip40_ovf0", 32'(overflow[0]), 1);
        do_ack();

        arm();
        set_exp(70, 0);
        pulse(2'b01, 70, 1);
        done_ok = 1'b1;
        wait_ready();
        chk("sat70_cnt", 32'(dut.cnt[0]), 63);
        chk("sat70_ch0", 32'(q_measured[9:0]), 1023);
        chk("sat70_ovf0", 32'(overflow[0]), 1);
        do_ack();

        arm();
        pulse(2'b01, 3, 1);
        start = 1'b0;
        tick(1);
        chk("abort_idle", 32'(busy), 0);
        tick(4);
        chk("abort_no_ready", 32'(ready), 0);
        chk("abort_q_held", 32'(q_measured[9:0]), 1023);
        arm();
        set_exp(2, 0);
        pulse(2'b01, 2, 1);
        done_ok = 1'b1;
        wait_ready();
        chk("restart_ch0_60", 32'(q_measured[9:0]), 60);
        do_ack();

        arm();
        set_exp(4, 0);
        pulse(2'b01, 4, 3);
        done_ok = 1'b1;
        wait_ready();
        chk("wdog_edge_wins", 32'(q_measured[9:0]), 120);
        do_ack();

        arm();
        set_exp(1, 0);
        done_ok = 1'b1;
        pulse(2'b01, 2, 4);
        wait_ready();
        chk("wdog_expires", 32'(q_measured[9:0]), 30);
        do_ack();

        arm();
`ifdef Q_MEAS_TIMEOUT_EN
        set_exp(0, 0);
        exp_to  = 1'b1;
        done_ok = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            tick(1);
            n++;
        end
        chk("timeout_latency", 32'(n), 16);
        chk("timeout_flag", 32'(timeout), 1);
        chk("timeout_q0", 32'(q_measured), 0);
        do_ack();
        exp_to = 1'b0;
`else
        n = 0;
        repeat (40) begin
            tick(1);
            n += int'(busy);
        end
        chk("no_timeout_busy", 32'(n), 40);
        chk("no_timeout_ready", 32'(ready), 0);
        start = 1'b0;
        tick(1);
`endif

        arm();
        pulse(2'b01, 2, 1);
        chk("mid_measure_busy", 32'(busy), 1);
        #2;
        rst_n  = 1'b0;
        held_q = '0;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_ready", 32'(ready), 0);
        chk("async_rst_q", 32'(q_measured), 0);
        chk("async_rst_ovf", 32'(overflow), 0);
        chk("async_rst_timeout", 32'(timeout), 0);
        chk("async_rst_cnt", 32'(dut.cnt[0]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/q_measurement_mc.md
Q_MEASUREMENT_MC -- requirements
Module: q_measurement_mc

Interface
REQ-001 The parameter N_CH SHALL default to 4 and set the number of independent pulse input channels (1..16).
REQ-002 The parameter BUS_WIDTH SHALL default to 10 and set the width of each channel's q_measured result.
REQ-003 The parameter CNT_WIDTH SHALL default to 8 and set the width of each channel's pulse counter.
REQ-004 The parameter WTD_WIDTH SHALL default to 2 and set the watchdog width (WTD_MAX = 2**WTD_WIDTH-1).
REQ-005 The parameter Q_PER_PULSE SHALL default to 30 and set the charge weight of one pulse.
REQ-006 The parameter ARM_TIMEOUT SHALL default to 1024 and set the cycle limit for waiting on a first pulse (used only under REQ-030).
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  level enable; measurement runs while high; a low level aborts.
REQ-010 ack  input  1  one-cycle result acknowledge; honoured only in DONE.
REQ-011 q_serialized  input  N_CH  asynchronous pulse trains, one bit per channel.
REQ-012 busy  output  1  high in ARMED and MEASURE.
REQ-013 ready  output  1  high only in DONE.
REQ-014 q_measured  output  N_CH*BUS_WIDTH  per-channel results; channel i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
REQ-015 overflow  output  N_CH  per-channel saturation flags, valid while ready is high.
REQ-016 timeout  output  1  high in DONE when it was entered by the arm timeout.

Function
REQ-017 Each q_serialized bit SHALL pass a 2-flop synchroniser plus an edge register; a rising edge SHALL increment that channel's counter on the 3rd clk edge after the input is first sampled high.
REQ-018 The FSM SHALL have the states IDLE, ARMED, MEASURE and DONE, and SHALL abort from any state to IDLE on the clock edge where start is sampled low.
REQ-019 IDLE->ARMED SHALL occur only on a start rising edge (start was low the previous cycle); on this transition all counters, overflow and timeout SHALL clear.
REQ-020 ARMED->MEASURE SHALL occur on the first detected edge on any channel; that edge SHALL be counted.
REQ-021 The watchdog SHALL load WTD_MAX on entry to MEASURE and on any cycle with an edge on any channel; otherwise it SHALL decrement by 1 per cycle.
REQ-022 MEASURE->DONE SHALL occur when the watchdog equals 0 and no edge is detected in that cycle; if an edge coincides with watchdog==0, the edge SHALL win, be counted and reload the watchdog.
REQ-023 On entry to DONE, each channel's q_measured SHALL latch min(count*Q_PER_PULSE, 2**BUS_WIDTH-1), computed at full width CNT_WIDTH+clog2(Q_PER_PULSE+1) bits.
REQ-024 overflow[i] SHALL be set if counter i saturated at 2**CNT_WIDTH-1 (further edges ignored) or if the result was clipped.
REQ-025 In DONE, edges SHALL be ignored; ack SHALL return the FSM to IDLE on the next edge, dropping ready, and q_measured SHALL hold its value until the next DONE entry.
REQ-026 ack outside DONE SHALL have no effect; start staying high after ack SHALL NOT re-arm.
REQ-027 An abort SHALL NOT update q_measured, and counts in progress SHALL be discarded.

Reset
REQ-028 While rst_n is low, the FSM SHALL be IDLE; busy, ready, timeout, overflow, q_measured, counters and synchronisers SHALL be 0; the watchdog SHALL be WTD_MAX.
REQ-029 Reset SHALL take effect immediately without clk; deassertion SHALL be used only synchronised to clk, and a reset mid-measurement SHALL discard all state.

Configuration
REQ-030 With Q_MEAS_TIMEOUT_EN defined, ARMED SHALL go to DONE with all results 0 and timeout=1 after ARM_TIMEOUT consecutive cycles without an edge.
REQ-031 Without Q_MEAS_TIMEOUT_EN, ARMED SHALL wait indefinitely, no timeout counter SHALL be synthesised, and timeout SHALL be tied to 0.

Verification (N_CH=2, BUS_WIDTH=10, CNT_WIDTH=6, WTD_WIDTH=2, Q_PER_PULSE=30, ARM_TIMEOUT=16)
REQ-032 Assert rst_n low mid-MEASURE -> all outputs 0 at once, without clk.
REQ-033 Start rising, then 5 pulses on ch0 and 3 on ch1 (1 clk high, 1 clk low) -> ready; ch0=150, ch1=90, overflow=00; ready holds until ack, then drops 1 clk later.
REQ-034 40 pulses on ch0 -> ch0=1023, overflow[0]=1; 70 pulses -> counter holds 63, ch0=1023, overflow[0]=1.
REQ-035 Drop start after 3 pulses -> IDLE next clk, ready never high, q_measured unchanged; re-start plus 2 pulses -> ch0=60.
REQ-036 Pulse gap such that an edge lands exactly when watchdog==0 -> no DONE, count includes the edge.
REQ-037 With Q_MEAS_TIMEOUT_EN, start and no pulses -> DONE 16 cycles after ARMED entry, timeout=1, results 0; without the macro -> busy stays high and ready stays low.
